cond_flag_unit: RTL and testbench
=================================

# cond_flag_unit

Conditional-execution and status-flag unit for the single-cycle ARM-subset CPU. It is the consumer of the ALU decoder's `ALU_Control`-side outputs `Flag_W` and `dontWrite`. It holds the architectural NZCV flags, writes them when an instruction's flag-write enables and condition allow it, and evaluates each instruction's 4-bit condition field against the stored flags. It gates the main decoder's register-write, memory-write and PC-write requests, and keeps saturating executed and skipped instruction counters for debug.

## Interface
Parameters:
- CNT_W, default 16: width of the executed and skipped counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  instruction valid this cycle. When low, nothing commits and the write outputs are 0.
- Cond  in  4  instruction bits [31:28].
- ALU_Flags  in  4  {N,Z,C,V} result flags from the ALU for the current instruction.
- Flag_W  in  2  from the ALU decoder. Bit 1 enables the N,Z write; bit 0 enables the C,V write.
- dontWrite  in  1  from the ALU decoder. High for CMP, and suppresses the register write.
- PC_S  in  1  main decoder PC-write request.
- Reg_W  in  1  main decoder register-write request.
- Mem_W  in  1  main decoder memory-write request.
- clr_cnt  in  1  synchronous clear of both counters.
- Flags  out  4  registered {N,Z,C,V}.
- Cond_Ex  out  1  combinational: the condition passes against `Flags`.
- PC_Src  out  1  en & Cond_Ex & PC_S.
- Reg_Write  out  1  en & Cond_Ex & Reg_W & ~dontWrite.
- Mem_Write  out  1  en & Cond_Ex & Mem_W.
- Exec_Count  out  CNT_W  number of instructions with en=1 and Cond_Ex=1.
- Skip_Count  out  CNT_W  number of instructions with en=1 and Cond_Ex=0.

## Operation
- Condition decode uses the stored `Flags`, never `ALU_Flags`. Cond_Ex is 1 as follows:
  - EQ 0000: Z. NE 0001: ~Z.
  - CS 0010: C. CC 0011: ~C.
  - MI 0100: N. PL 0101: ~N.
  - VS 0110: V. VC 0111: ~V.
  - HI 1000: C&~Z. LS 1001: ~C|Z.
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: ~Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110: 1.
  - 1111: unconditional-extension space, unsupported; Cond_Ex = 0, so the instruction is skipped.
- Flag update at a rising edge when en & Cond_Ex:
  - N,Z ← ALU_Flags[3:2] if Flag_W[1].
  - C,V ← ALU_Flags[1:0] if Flag_W[0].
  - The two halves update independently. Flag_W=2'b10 (logical S-ops) updates N,Z only and leaves C,V unchanged.
- A failed condition writes no flags, even if Flag_W≠0.
- Counters at a rising edge, when en=1:
  - Exec_Count += 1 if Cond_Ex, otherwise Skip_Count += 1.
  - Each counter saturates at all-ones and does not wrap.
  - clr_cnt has priority over the increment. Clear together with a qualifying instruction gives 0, not 1.
- en=0: flags and counters hold, and PC_Src, Reg_Write and Mem_Write are 0.
- CMP (dontWrite=1, Flag_W=11, Reg_W=1): flags are written if the condition passes, and Reg_Write = 0.
- dontWrite does not gate Mem_Write or PC_Src.

## Timing
- Reset (reset_n low, asynchronous) forces:
  - Flags = 4'b0000, Exec_Count = 0, Skip_Count = 0.
  - Cond_Ex then reflects zero flags, e.g. EQ → 0, NE → 1, AL → 1.
  - Write outputs stay combinational and are 0 whenever en=0.
- Reset asserted mid-instruction: state clears immediately and no partial flag write survives. Deassertion is sampled synchronously by the surrounding reset synchroniser.
- Cond_Ex, PC_Src, Reg_Write and Mem_Write are purely combinational from the current inputs and registered Flags, with zero-cycle latency. This fits the single-cycle datapath.
- New flags are visible to the next instruction, one cycle later. An instruction never sees its own flag result in its own Cond_Ex.
- Back-to-back flag-setting instructions: each one's condition is evaluated against the flags left by its predecessor.
- No combinational path from ALU_Flags to any output; ALU_Flags reaches only the flag register D inputs.

## Test plan
- Reset, then Cond=0000 (EQ), en=1, Reg_W=1 → Cond_Ex=0, Reg_Write=0, Skip_Count=1. Then Cond=0001 → Reg_Write=1, Exec_Count=1.
- CMP equal operands: Cond=1110, Flag_W=11, dontWrite=1, Reg_W=1, ALU_Flags=0110 → Reg_Write=0 in that cycle; next cycle Flags=0110 and Cond=0000 gives Cond_Ex=1.
- Partial update: Flags=0011, then ANDS with Flag_W=10, ALU_Flags=1000 → Flags=1011, with C,V preserved.
- Failed condition with Flag_W=11: Flags=0000, Cond=0000, ALU_Flags=1111 → Flags stays 0000, Mem_Write=0, PC_Src=0.
- Signed conditions: Flags N=1,V=0 → GE=0, LT=1, GT=0, LE=1. Flags N=1,V=1,Z=0 → GE=1, GT=1. Cond=1111 → Cond_Ex=0.
- Counters with CNT_W=4:
  - 17 AL instructions → Exec_Count=15, saturated.
  - clr_cnt together with an AL instruction → Exec_Count=0.
  - reset_n pulsed low mid-cycle → both counters 0 and Flags 0 immediately.

Source files
------------

// File: rtl/cond_flag_unit.sv
// Conditional-execution and NZCV flag unit for the single-cycle CPU.
// Gates the decoder's write requests on the condition field and counts executed/skipped instructions.
module cond_flag_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALU_Flags,
   input  logic [1:0]       Flag_W,
   input  logic             dontWrite,
   input  logic             PC_S,
   input  logic             Reg_W,
   input  logic             Mem_W,
   input  logic             clr_cnt,
   output logic [3:0]       Flags,
   output logic             Cond_Ex,
   output logic             PC_Src,
   output logic             Reg_Write,
   output logic             Mem_Write,
   output logic [CNT_W-1:0] Exec_Count,
   output logic [CNT_W-1:0] Skip_Count
);

   logic flag_n, flag_z, flag_c, flag_v;
   logic commit;

   assign flag_n = Flags[3];
   assign flag_z = Flags[2];
   assign flag_c = Flags[1];
   assign flag_v = Flags[0];

   // Condition is judged only against the stored flags, so an instruction never sees its own result.
   always_comb begin
      Cond_Ex = 1'b0;
      unique case (Cond)
         4'b0000: Cond_Ex = flag_z;
         4'b0001: Cond_Ex = ~flag_z;
         4'b0010: Cond_Ex = flag_c;
         4'b0011: Cond_Ex = ~flag_c;
         4'b0100: Cond_Ex = flag_n;
         4'b0101: Cond_Ex = ~flag_n;
         4'b0110: Cond_Ex = flag_v;
         4'b0111: Cond_Ex = ~flag_v;
         4'b1000: Cond_Ex = flag_c & ~flag_z;
         4'b1001: Cond_Ex = ~flag_c | flag_z;
         4'b1010: Cond_Ex = (flag_n == flag_v);
         4'b1011: Cond_Ex = (flag_n != flag_v);
         4'b1100: Cond_Ex = ~flag_z & (flag_n == flag_v);
         4'b1101: Cond_Ex = flag_z | (flag_n != flag_v);
         4'b1110: Cond_Ex = 1'b1;
         4'b1111: Cond_Ex = 1'b0;
         default: Cond_Ex = 1'b0;
      endcase
   end

   assign commit    = en & Cond_Ex;
   assign PC_Src    = commit & PC_S;
   assign Reg_Write = commit & Reg_W & ~dontWrite;
   assign Mem_Write = commit & Mem_W;

   // N,Z and C,V halves are written independently so logical S-ops keep the carry and overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         Flags <= 4'b0000;
      end else if (commit) begin
         if (Flag_W[1]) Flags[3:2] <= ALU_Flags[3:2];
         if (Flag_W[0]) Flags[1:0] <= ALU_Flags[1:0];
      end
   end

   // Saturating debug counters; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         Exec_Count <= '0;
         Skip_Count <= '0;
      end else if (clr_cnt) begin
         Exec_Count <= '0;
         Skip_Count <= '0;
      end else if (en) begin
         if (Cond_Ex) begin
            if (Exec_Count != {CNT_W{1'b1}}) Exec_Count <= Exec_Count + 1'b1;
         end else begin
            if (Skip_Count != {CNT_W{1'b1}}) Skip_Count <= Skip_Count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed self-checking bench for cond_flag_unit, built with 4-bit counters to reach saturation quickly.
module tb_cond_flag_unit;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             en;
   logic [3:0]       Cond;
   logic [3:0]       ALU_Flags;
   logic [1:0]       Flag_W;
   logic             dontWrite;
   logic             PC_S;
   logic             Reg_W;
   logic             Mem_W;
   logic             clr_cnt;
   logic [3:0]       Flags;
   logic             Cond_Ex;
   logic             PC_Src;
   logic             Reg_Write;
   logic             Mem_Write;
   logic [CNT_W-1:0] Exec_Count;
   logic [CNT_W-1:0] Skip_Count;

   int nChecks = 0;
   int nFails  = 0;

   cond_flag_unit #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .Cond       (Cond),
      .ALU_Flags  (ALU_Flags),
      .Flag_W     (Flag_W),
      .dontWrite  (dontWrite),
      .PC_S       (PC_S),
      .Reg_W      (Reg_W),
      .Mem_W      (Mem_W),
      .clr_cnt    (clr_cnt),
      .Flags      (Flags),
      .Cond_Ex    (Cond_Ex),
      .PC_Src     (PC_Src),
      .Reg_Write  (Reg_Write),
      .Mem_Write  (Mem_Write),
      .Exec_Count (Exec_Count),
      .Skip_Count (Skip_Count)
   );

   always #5 clk = ~clk;

   // Drives one instruction's inputs just after a falling edge and lets combinational outputs settle.
   task automatic applyStimulus(input logic e, input logic [3:0] c, input logic [3:0] af,
                                input logic [1:0] fw, input logic dw, input logic ps,
                                input logic rw, input logic mw, input logic clr);
      @(negedge clk);
      en = e; Cond = c; ALU_Flags = af; Flag_W = fw; dontWrite = dw;
      PC_S = ps; Reg_W = rw; Mem_W = mw; clr_cnt = clr;
      #1;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic loadFlags(input logic [3:0] v);
      applyStimulus(1'b1, 4'b1110, v, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepClock();
      applyStimulus(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset_n = 1'b0;
      #2;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      doReset();
      applyStimulus(1'b0, 4'b0000, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      nChecks++;
      if (Flags !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_flags got=%b exp=0000", Flags); end
      nChecks++;
      if (Exec_Count !== 4'd0 || Skip_Count !== 4'd0) begin
         nFails++; $display("[TB] FAIL reset_counts got exec=%0d skip=%0d exp 0/0", Exec_Count, Skip_Count);
      end
      nChecks++;
      if (Cond_Ex !== 1'b0) begin nFails++; $display("[TB] FAIL reset_eq got=%b exp=0", Cond_Ex); end
      nChecks++;
      if ({PC_Src, Reg_Write, Mem_Write} !== 3'b000) begin
         nFails++; $display("[TB] FAIL reset_en_low_writes got=%b exp=000", {PC_Src, Reg_Write, Mem_Write});
      end
      applyStimulus(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nChecks++;
      if (Cond_Ex !== 1'b1) begin nFails++; $display("[TB] FAIL reset_al got=%b exp=1", Cond_Ex); end
   endtask

   task automatic test_cond_basic();
      applyStimulus(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      nChecks++;
      if (Cond_Ex !== 1'b0 || Reg_Write !== 1'b0) begin
         nFails++; $display("[TB] FAIL eq_skip got cond=%b rw=%b exp 0/0", Cond_Ex, Reg_Write);
      end
      stepClock();
      nChecks++;
      if (Skip_Count !== 4'd1 || Exec_Count !== 4'd0) begin
         nFails++; $display("[TB] FAIL eq_skip_count got exec=%0d skip=%0d exp 0/1", Exec_Count, Skip_Count);
      end
      applyStimulus(1'b1, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      nChecks++;
      if (Reg_Write !== 1'b1) begin nFails++; $display("[TB] FAIL ne_regwrite got=%b exp=1", Reg_Write); end
      stepClock();
      nChecks++;
      if (Exec_Count !== 4'd1 || Skip_Count !== 4'd1) begin
         nFails++; $display("[TB] FAIL ne_exec_count got exec=%0d skip=%0d exp 1/1", Exec_Count, Skip_Count);
      end
   endtask

   task automatic test_cmp();
      doReset();
      applyStimulus(1'b1, 4'b1110, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      nChecks++;
      if (Reg_Write !== 1'b0) begin nFails++; $display("[TB] FAIL cmp_regwrite got=%b exp=0", Reg_Write); end
      nChecks++;
      if (Mem_Write !== 1'b1 || PC_Src !== 1'b1) begin
         nFails++; $display("[TB] FAIL cmp_mem_pc got mw=%b pc=%b exp 1/1", Mem_Write, PC_Src);
      end
      nChecks++;
      if (Flags !== 4'b0000) begin nFails++; $display("[TB] FAIL cmp_flags_same_cycle got=%b exp=0000", Flags); end
      stepClock();
      nChecks++;
      if (Flags !== 4'b0110) begin nFails++; $display("[TB] FAIL cmp_flags got=%b exp=0110", Flags); end
      applyStimulus(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      nChecks++;
      if (Cond_Ex !== 1'b1 || Reg_Write !== 1'b1) begin
         nFails++; $display("[TB] FAIL cmp_then_eq got cond=%b rw=%b exp 1/1", Cond_Ex, Reg_Write);
      end
   endtask

   task automatic test_partial_update();
      loadFlags(4'b0011);
      applyStimulus(1'b1, 4'b1110, 4'b1000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      stepClock();
      nChecks++;
      if (Flags !== 4'b1011) begin nFails++; $display("[TB] FAIL partial_nz got=%b exp=1011", Flags); end
      applyStimulus(1'b1, 4'b1110, 4'b0100, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      stepClock();
      nChecks++;
      if (Flags !== 4'b1000) begin nFails++; $display("[TB] FAIL partial_cv got=%b exp=1000", Flags); end
   endtask

   task automatic test_failed_cond();
      loadFlags(4'b0000);
      applyStimulus(1'b1, 4'b0000, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      nChecks++;
      if ({PC_Src, Reg_Write, Mem_Write} !== 3'b000) begin
         nFails++; $display("[TB] FAIL failed_cond_writes got=%b exp=000", {PC_Src, Reg_Write, Mem_Write});
      end
      stepClock();
      nChecks++;
      if (Flags !== 4'b0000) begin nFails++; $display("[TB] FAIL failed_cond_flags got=%b exp=0000", Flags); end
   endtask

   task automatic test_signed_conds();
      logic [3:0] condList [4] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101};
      logic       expA     [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic       expB     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      loadFlags(4'b1000);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, condList[i], 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         nChecks++;
         if (Cond_Ex !== expA[i]) begin
            nFails++; $display("[TB] FAIL signed_n1v0 cond=%b got=%b exp=%b", condList[i], Cond_Ex, expA[i]);
         end
      end
      loadFlags(4'b1001);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, condList[i], 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         nChecks++;
         if (Cond_Ex !== expB[i]) begin
            nFails++; $display("[TB] FAIL signed_n1v1 cond=%b got=%b exp=%b", condList[i], Cond_Ex, expB[i]);
         end
      end
      loadFlags(4'b0010);
      applyStimulus(1'b0, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nChecks++;
      if (Cond_Ex !== 1'b1) begin nFails++; $display("[TB] FAIL hi_c1z0 got=%b exp=1", Cond_Ex); end
      applyStimulus(1'b0, 4'b1001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nChecks++;
      if (Cond_Ex !== 1'b0) begin nFails++; $display("[TB] FAIL ls_c1z0 got=%b exp=0", Cond_Ex); end
      loadFlags(4'b1111);
      applyStimulus(1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      nChecks++;
      if (Cond_Ex !== 1'b0 || {PC_Src, Reg_Write, Mem_Write} !== 3'b000) begin
         nFails++; $display("[TB] FAIL nv_cond got cond=%b writes=%b exp 0/000", Cond_Ex, {PC_Src, Reg_Write, Mem_Write});
      end
   endtask

   task automatic test_back_to_back();
      loadFlags(4'b0000);
      applyStimulus(1'b1, 4'b0000, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nChecks++;
      if (Cond_Ex !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_own_result got=%b exp=0", Cond_Ex); end
      applyStimulus(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepClock();
      applyStimulus(1'b1, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nChecks++;
      if (Cond_Ex !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_second got=%b exp=1", Cond_Ex); end
      stepClock();
      applyStimulus(1'b1, 4'b0000, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nChecks++;
      if (Cond_Ex !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_third got=%b exp=0", Cond_Ex); end
      stepClock();
      nChecks++;
      if (Flags !== 4'b0000) begin nFails++; $display("[TB] FAIL b2b_flags got=%b exp=0000", Flags); end
   endtask

   task automatic test_en_low();
      logic [CNT_W-1:0] e0, s0;
      loadFlags(4'b0101);
      e0 = Exec_Count;
      s0 = Skip_Count;
      applyStimulus(1'b0, 4'b1110, 4'b1010, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      nChecks++;
      if ({PC_Src, Reg_Write, Mem_Write} !== 3'b000) begin
         nFails++; $display("[TB] FAIL en_low_writes got=%b exp=000", {PC_Src, Reg_Write, Mem_Write});
      end
      stepClock();
      nChecks++;
      if (Flags !== 4'b0101 || Exec_Count !== e0 || Skip_Count !== s0) begin
         nFails++; $display("[TB] FAIL en_low_hold got flags=%b exec=%0d skip=%0d exp %b/%0d/%0d",
                            Flags, Exec_Count, Skip_Count, 4'b0101, e0, s0);
      end
   endtask

   task automatic test_saturation();
      applyStimulus(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      stepClock();
      nChecks++;
      if (Exec_Count !== 4'd0 || Skip_Count !== 4'd0) begin
         nFails++; $display("[TB] FAIL clear_idle got exec=%0d skip=%0d exp 0/0", Exec_Count, Skip_Count);
      end
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         stepClock();
      end
      nChecks++;
      if (Exec_Count !== 4'd15) begin nFails++; $display("[TB] FAIL exec_saturate got=%0d exp=15", Exec_Count); end
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         stepClock();
      end
      nChecks++;
      if (Skip_Count !== 4'd15) begin nFails++; $display("[TB] FAIL skip_saturate got=%0d exp=15", Skip_Count); end
      applyStimulus(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      stepClock();
      nChecks++;
      if (Exec_Count !== 4'd0 || Skip_Count !== 4'd0) begin
         nFails++; $display("[TB] FAIL clear_priority got exec=%0d skip=%0d exp 0/0", Exec_Count, Skip_Count);
      end
   endtask

   task automatic test_async_reset();
      loadFlags(4'b1101);
      applyStimulus(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepClock();
      applyStimulus(1'b1, 4'b1111, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepClock();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      nChecks++;
      if (Flags !== 4'b0000 || Exec_Count !== 4'd0 || Skip_Count !== 4'd0) begin
         nFails++; $display("[TB] FAIL async_reset got flags=%b exec=%0d skip=%0d exp 0000/0/0",
                            Flags, Exec_Count, Skip_Count);
      end
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_n = 1'b1;
      en = 1'b0; Cond = 4'b0; ALU_Flags = 4'b0; Flag_W = 2'b0; dontWrite = 1'b0;
      PC_S = 1'b0; Reg_W = 1'b0; Mem_W = 1'b0; clr_cnt = 1'b0;
      test_reset();
      test_cond_basic();
      test_cmp();
      test_partial_update();
      test_failed_cond();
      test_signed_conds();
      test_back_to_back();
      test_en_low();
      test_saturation();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   // Guards against a stuck run so the bench always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
